// File: rtl/decrypt_scan_ctrl.sv
// Image scan sequencer: reads each pixel from source memory, passes it through
// the decrypt core handshake, and writes the result to destination memory.
module decrypt_scan_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NPIX   = 65536
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_src_rd,
    output logic [ADDR_W-1:0] o_src_addr,
    input  logic [DATA_W-1:0] i_src_data,
    output logic              o_dec_req,
    output logic [DATA_W-1:0] o_dec_din,
    input  logic              i_dec_ack,
    input  logic [DATA_W-1:0] i_dec_dout,
    output logic              o_dst_we,
    output logic [ADDR_W-1:0] o_dst_addr,
    output logic [DATA_W-1:0] o_dst_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_pix_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_RD,
        S_REQ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_hold;
    logic [DATA_W-1:0]   r_result;
    logic                r_src_rd;
    logic                r_dec_req;
    logic                r_dst_we;
    logic                r_busy;
    logic                r_done;

    // Strobes are registered alongside the transition into the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_hold    <= '0;
            r_result  <= '0;
            r_src_rd  <= 1'b0;
            r_dec_req <= 1'b0;
            r_dst_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_src_rd  <= 1'b0;
            r_dec_req <= 1'b0;
            r_dst_we  <= 1'b0;
            r_done    <= 1'b0;
            if (i_abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_abort) begin
                            r_state  <= S_READ;
                            r_addr   <= '0;
                            r_src_rd <= 1'b1;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_READ: begin
                        r_state <= S_WAIT_RD;
                    end
                    S_WAIT_RD: begin
                        r_hold    <= i_src_data;
                        r_state   <= S_REQ;
                        r_dec_req <= 1'b1;
                    end
                    S_REQ: begin
                        if (i_dec_ack) begin
                            r_result <= i_dec_dout;
                            r_state  <= S_WRITE;
                            r_dst_we <= 1'b1;
                        end else begin
                            r_dec_req <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (r_addr == LAST_ADDR) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr   <= r_addr + 1'b1;
                            r_state  <= S_READ;
                            r_src_rd <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A reset landing on a write cycle must not commit the pixel.
    assign o_dst_we    = r_dst_we & ~i_rst;
    assign o_src_rd    = r_src_rd;
    assign o_dec_req   = r_dec_req;
    assign o_done      = r_done;
    assign o_busy      = r_busy;
    assign o_src_addr  = r_addr;
    assign o_dst_addr  = r_addr;
    assign o_pix_count = r_addr;
    assign o_dec_din   = r_hold;
    assign o_dst_data  = r_result;

endmodule

// File: tb/tb_decrypt_scan_ctrl.sv
// Directed bench for decrypt_scan_ctrl: 4-pixel image with an XOR-0xA5 core
// model, plus a 1-pixel instance for the single-pixel corner.
module tb_decrypt_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic        src_rd, dec_req, dst_we, busy, done, dec_ack;
    logic [15:0] src_addr, dst_addr, pix_count;
    logic [7:0]  src_data, dec_din, dec_dout, dst_data;

    logic        src_rd1, dec_req1, dst_we1, busy1, done1, dec_ack1;
    logic [15:0] src_addr1, dst_addr1, pix_count1;
    logic [7:0]  src_data1, dec_din1, dec_dout1, dst_data1;

    always #5 clk = ~clk;

    decrypt_scan_ctrl #(.ADDR_W(16), .DATA_W(8), .NPIX(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .o_src_rd(src_rd), .o_src_addr(src_addr), .i_src_data(src_data),
        .o_dec_req(dec_req), .o_dec_din(dec_din), .i_dec_ack(dec_ack),
        .i_dec_dout(dec_dout), .o_dst_we(dst_we), .o_dst_addr(dst_addr),
        .o_dst_data(dst_data), .o_busy(busy), .o_done(done), .o_pix_count(pix_count)
    );

    decrypt_scan_ctrl #(.ADDR_W(16), .DATA_W(8), .NPIX(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .o_src_rd(src_rd1), .o_src_addr(src_addr1), .i_src_data(src_data1),
        .o_dec_req(dec_req1), .o_dec_din(dec_din1), .i_dec_ack(dec_ack1),
        .i_dec_dout(dec_dout1), .o_dst_we(dst_we1), .o_dst_addr(dst_addr1),
        .o_dst_data(dst_data1), .o_busy(busy1), .o_done(done1), .o_pix_count(pix_count1)
    );

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] exp;
        int          delay;
        int          lat;
    } vec_t;

    vec_t        vecs[4];
    logic [7:0]  mem[4];
    logic [7:0]  dst_mem[4];
    bit          wrote[4];
    int          n_vec = 0, n_err = 0;
    int          ncyc = 0, ack_delay = 0, req_cnt = 0;
    int          wr_cnt, done_cnt, done_t, din_unstable;
    int          wr1_cnt, wr1_addr, wr1_data, wr1_t, done1_cnt, done1_t;
    logic        prev_req = 1'b0;
    logic [7:0]  prev_din = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; done_t = -1000; din_unstable = 0;
        wr1_cnt = 0; wr1_addr = -1; wr1_data = -1; wr1_t = -1000;
        done1_cnt = 0; done1_t = -1000;
        for (int i = 0; i < 4; i++) begin
            dst_mem[i] = 8'h00;
            wrote[i]   = 1'b0;
        end
    endtask

    // One clock: sample DUT outputs at the falling edge and drive model responses.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (src_rd) src_data = mem[src_addr[1:0]];
        if (dec_req && prev_req && (dec_din != prev_din)) din_unstable++;
        prev_req = dec_req;
        prev_din = dec_din;
        if (dec_req) begin
            if (req_cnt == ack_delay) begin
                dec_ack  = 1'b1;
                dec_dout = dec_din ^ 8'hA5;
                req_cnt  = 0;
            end else begin
                dec_ack = 1'b0;
                req_cnt++;
            end
        end else begin
            dec_ack = 1'b0;
            req_cnt = 0;
        end
        if (dst_we) begin
            wr_cnt++;
            dst_mem[dst_addr[1:0]] = dst_data;
            wrote[dst_addr[1:0]]   = 1'b1;
        end
        if (done) begin
            done_cnt++;
            done_t = ncyc;
        end
        src_data1 = 8'hFF;
        dec_ack1  = dec_req1;
        dec_dout1 = dec_din1 ^ 8'hA5;
        if (dst_we1) begin
            wr1_cnt++;
            wr1_addr = int'(dst_addr1);
            wr1_data = int'(dst_data1);
            wr1_t    = ncyc;
        end
        if (done1) begin
            done1_cnt++;
            done1_t = ncyc;
        end
    endtask

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < 4; i++) mem[i] = v.src[8*i +: 8];
    endtask

    task automatic run_scan(input int delay, output int lat, output int timed_out);
        int t_s;
        clear_mon();
        ack_delay = delay;
        start = 1'b1;
        t_s = ncyc;
        tick();
        start = 1'b0;
        timed_out = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_cnt > 0) begin
                timed_out = 0;
                break;
            end
        end
        repeat (5) tick();
        lat = done_t - t_s - 1;
    endtask

    task automatic chk_image(input string name, input vec_t v);
        for (int i = 0; i < 4; i++) chk({name, "_dst"}, int'(dst_mem[i]), int'(v.exp[8*i +: 8]));
        chk({name, "_wr_cnt"}, wr_cnt, 4);
        chk({name, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        int lat, to, found;
        vecs[0] = '{src: 32'h40302010, exp: 32'hE59585B5, delay: 0, lat: 16};
        vecs[1] = '{src: 32'h40302010, exp: 32'hE59585B5, delay: 3, lat: 28};
        vecs[2] = '{src: 32'hA55AFF00, exp: 32'h00FF5AA5, delay: 1, lat: 20};
        vecs[3] = '{src: 32'h8001C33C, exp: 32'h25A46699, delay: 2, lat: 24};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_data = 8'h00; dec_ack = 1'b0; dec_dout = 8'h00;
        src_data1 = 8'h00; dec_ack1 = 1'b0; dec_dout1 = 8'h00;
        clear_mon();
        load_mem(vecs[0]);

        // Reset state, with start held high to show reset has priority.
        tick();
        start = 1'b1;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({src_rd, dec_req, dst_we, done}), 0);
        chk("rst_addrs", int'({src_addr, dst_addr, pix_count}), 0);
        chk("rst_data", int'({dst_data, dec_din}), 0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) begin
            load_mem(vecs[k]);
            run_scan(vecs[k].delay, lat, to);
            chk("scan_timeout", to, 0);
            chk_image("scan", vecs[k]);
            chk("scan_latency", lat, vecs[k].lat);
            chk("din_stable", din_unstable, 0);
            chk("end_pix_count", int'(pix_count), 3);
            chk("end_busy", int'(busy), 0);
        end

        // Abort together with ack in the request phase of pixel 2.
        load_mem(vecs[0]);
        clear_mon();
        ack_delay = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dec_req && pix_count == 16'd2) begin
                found = 1;
                break;
            end
        end
        chk("abort_reach_req2", found, 1);
        chk("abort_ack_driven", int'(dec_ack), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_strobes", int'({src_rd, dec_req, dst_we, done}), 0);
        repeat (20) tick();
        chk("abort_no_wr2", int'(wrote[2]), 0);
        chk("abort_wr_cnt", wr_cnt, 2);
        chk("abort_no_done", done_cnt, 0);
        run_scan(0, lat, to);
        chk("rescan_timeout", to, 0);
        chk_image("rescan", vecs[0]);

        // Start pulses while busy outside the request phase are ignored.
        clear_mon();
        ack_delay = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            start = busy && !dec_req && !done;
        end
        start = 1'b0;
        tick();
        chk_image("start_ign", vecs[0]);
        chk("start_ign_busy", int'(busy), 0);

        // Reset landing on the write of pixel 1.
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dst_we && dst_addr == 16'd1) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach_wr1", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_wr_masked", int'(dst_we), 0);
        tick();
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_strobes", int'({src_rd, dec_req, dst_we, done}), 0);
        chk("rst_mid_addrs", int'({src_addr, dst_addr, pix_count}), 0);
        chk("rst_mid_data", int'({dst_data, dec_din}), 0);
        rst = 1'b0;
        tick();
        run_scan(0, lat, to);
        chk("post_rst_timeout", to, 0);
        chk_image("post_rst", vecs[0]);
        chk("post_rst_latency", lat, 16);

        // Single-pixel image on the NPIX=1 instance.
        clear_mon();
        start = 1'b1;
        lat = ncyc;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("npix1_wr_cnt", wr1_cnt, 1);
        chk("npix1_wr_addr", wr1_addr, 0);
        chk("npix1_wr_data", wr1_data, 8'h5A);
        chk("npix1_done_cnt", done1_cnt, 1);
        chk("npix1_done_after_wr", done1_t - wr1_t, 1);
        chk("npix1_latency", done1_t - lat - 1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
